// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave (CLK_SLAVE, RESET_SLAVE active-low sync; HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA/HREADY in; HREADYOUT/HRESP/HRDATA out)
module ahb_sram_slave #(
  parameter int ADDR_BITS = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        CLK_SLAVE,
  input  logic        RESET_SLAVE,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;
  localparam int WORDS = 1 << (ADDR_BITS - 2);
  localparam logic [2:0] WS_LOAD = WAIT_STATES > 0 ? 3'(WAIT_STATES - 1) : 3'd0;
  logic [2:0] state, nxt, wcnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic write_q;
  logic [1:0] size_q;
  logic [3:0] be;
  logic [31:0] mem [WORDS];
  logic accept, err, done, unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign err = (|HADDR[31:ADDR_BITS]) | (HSIZE > 3'd2) | (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & |HADDR[1:0]);
  assign done = state == S_IDLE | state == S_DATA | state == S_ERR2;
  always_comb
    nxt = !done ? (state == S_ERR1 ? S_ERR2 : (wcnt == 3'd0 ? S_DATA : S_WAIT)) :
          !accept ? S_IDLE : err ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
  always_comb
    be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge CLK_SLAVE)
    if (!RESET_SLAVE) begin
      state <= S_IDLE;
      wcnt <= 3'd0;
    end else begin
      state <= nxt;
      wcnt <= (done & accept) ? WS_LOAD : (state == S_WAIT && wcnt != 3'd0) ? wcnt - 3'd1 : wcnt;
      if (done & accept) begin
        addr_q <= HADDR[ADDR_BITS-1:0];
        write_q <= HWRITE;
        size_q <= HSIZE[1:0];
      end
    end
  always_ff @(posedge CLK_SLAVE)
    if (RESET_SLAVE && state == S_DATA && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[ADDR_BITS-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
  assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
  assign HRESP = state == S_ERR1 || state == S_ERR2;
  assign HRDATA = (state == S_DATA && !write_q) ? mem[addr_q[ADDR_BITS-1:2]] : 32'd0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed-vector bench for ahb_sram_slave with 0 and 3 wait states
module tb_ahb_sram_slave;
  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  logic clk = 0, rstn = 0, use3 = 0;
  logic hsel0 = 0, hsel3 = 0, hwrite = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic [1:0] htrans = 0;
  logic ro0, ro3, resp0, resp3;
  logic [31:0] rd0, rd3;
  int vec = 0, bad = 0;
  always #5 clk = ~clk;
  ahb_sram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) u0 (
    .CLK_SLAVE(clk), .RESET_SLAVE(rstn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro0),
    .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0));
  ahb_sram_slave #(.ADDR_BITS(10), .WAIT_STATES(3)) u3 (
    .CLK_SLAVE(clk), .RESET_SLAVE(rstn), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro3),
    .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rd3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    hsel0 = sel & !use3;
    hsel3 = sel & use3;
    htrans = tr;
    hwrite = wr;
    hsize = sz;
    haddr = a;
    hwdata = wd;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) begin
      bus(0, IDL, 0, 0, 0, 0);
      chk("rst_ctl", {28'd0, ro0, resp0, ro3, resp3}, 32'h0000000A);
      chk("rst_rdata", rd0 | rd3, 32'd0);
    end
    rstn = 1;
    bus(1, NS, 1, 2, 32'h10, 0);
    chk("sw_addr_rdy", {31'd0, ro0}, 32'd1);
    bus(1, NS, 0, 2, 32'h10, 32'hDEADBEEF);
    chk("sw_wr_ctl", {30'd0, ro0, resp0}, 32'd2);
    chk("sw_wr_rdata", rd0, 32'd0);
    bus(0, IDL, 0, 2, 0, 0);
    chk("sw_rd", rd0, 32'hDEADBEEF);
    bus(1, NS, 1, 2, 32'h20, 0);
    bus(1, NS, 1, 0, 32'h21, 32'h11223344);
    bus(1, NS, 1, 1, 32'h22, 32'h0000AA00);
    bus(1, NS, 0, 2, 32'h20, 32'h55660000);
    bus(0, IDL, 0, 2, 0, 0);
    chk("lanes_rd", rd0, 32'h5566AA44);
    hburst = 3'b011;
    bus(1, NS, 1, 2, 32'h40, 0);
    bus(1, SQ, 1, 2, 32'h44, 1);
    chk("incr_wr_rdy1", {31'd0, ro0}, 32'd1);
    bus(1, SQ, 1, 2, 32'h48, 2);
    chk("incr_wr_rdy2", {31'd0, ro0}, 32'd1);
    bus(1, SQ, 1, 2, 32'h4C, 3);
    chk("incr_wr_rdy3", {31'd0, ro0}, 32'd1);
    bus(1, NS, 0, 2, 32'h40, 4);
    chk("incr_wr_rdy4", {31'd0, ro0}, 32'd1);
    bus(1, SQ, 0, 2, 32'h44, 0);
    chk("incr_rd1", {rd0[30:0], ro0}, 32'd3);
    bus(1, SQ, 0, 2, 32'h48, 0);
    chk("incr_rd2", {rd0[30:0], ro0}, 32'd5);
    bus(1, SQ, 0, 2, 32'h4C, 0);
    chk("incr_rd3", {rd0[30:0], ro0}, 32'd7);
    bus(0, IDL, 0, 2, 0, 0);
    chk("incr_rd4", {rd0[30:0], ro0}, 32'd9);
    bus(1, NS, 1, 2, 32'h40, 0);
    bus(1, BSY, 1, 2, 32'h48, 32'h99);
    bus(1, SQ, 1, 2, 32'h44, 32'hBAD);
    chk("busy_ctl", {30'd0, ro0, resp0}, 32'd2);
    bus(1, NS, 0, 2, 32'h48, 32'h55);
    bus(1, SQ, 0, 2, 32'h44, 0);
    chk("busy_nochg", rd0, 32'd3);
    bus(1, SQ, 0, 2, 32'h40, 0);
    chk("busy_next", rd0, 32'h55);
    bus(0, IDL, 0, 2, 0, 0);
    chk("busy_first", rd0, 32'h99);
    hburst = 3'b000;
    bus(1, NS, 1, 2, 32'h0, 0);
    bus(1, NS, 1, 2, 32'h400, 32'hCAFEF00D);
    bus(1, IDL, 0, 2, 0, 32'h11111111);
    chk("oor_err1", {30'd0, ro0, resp0}, 32'd1);
    bus(1, NS, 1, 2, 32'h02, 32'h11111111);
    chk("oor_err2", {30'd0, ro0, resp0}, 32'd3);
    bus(1, IDL, 0, 2, 0, 32'h22222222);
    chk("mis_err1", {30'd0, ro0, resp0}, 32'd1);
    bus(1, NS, 0, 2, 32'h0, 32'h22222222);
    chk("mis_err2", {30'd0, ro0, resp0}, 32'd3);
    bus(0, IDL, 0, 2, 0, 0);
    chk("err_ram", rd0, 32'hCAFEF00D);
    chk("err_after", {30'd0, ro0, resp0}, 32'd2);
    use3 = 1;
    bus(1, NS, 1, 2, 32'h80, 0);
    repeat (3) begin
      bus(1, IDL, 0, 2, 0, 32'hA5A55A5A);
      chk("ws_wr_wait", {30'd0, ro3, resp3}, 32'd0);
    end
    bus(1, IDL, 0, 2, 0, 32'hA5A55A5A);
    chk("ws_wr_done", {30'd0, ro3, resp3}, 32'd2);
    bus(1, NS, 0, 2, 32'h80, 0);
    n = 0;
    do begin
      bus(1, IDL, 0, 2, 0, 0);
      if (!ro3) begin
        n++;
        chk("ws_rd_zero", rd3, 32'd0);
      end
    end while (!ro3 && n < 10);
    chk("ws_rd_waits", n, 32'd3);
    chk("ws_rd_data", rd3, 32'hA5A55A5A);
    bus(1, NS, 1, 2, 32'h400, 0);
    bus(1, IDL, 0, 2, 0, 0);
    chk("ws_err1", {30'd0, ro3, resp3}, 32'd1);
    bus(1, IDL, 0, 2, 0, 0);
    chk("ws_err2", {30'd0, ro3, resp3}, 32'd3);
    bus(1, IDL, 0, 2, 0, 0);
    chk("ws_err_idle", {30'd0, ro3, resp3}, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite memory slave for the master/burst transfer path: it accepts the master's address and control, stores write data and returns read data from an internal word-organised RAM. It drives HREADY and HRESP back to the master. It supports single transfers and any INCR/WRAP burst, because the master supplies every beat address. A programmable wait-state counter and an error path for illegal accesses let the master's stall and abort handling be exercised.

## Interface
- ADDR_BITS, 10: byte-address bits decoded. RAM holds 2^(ADDR_BITS-2) 32-bit words.
- WAIT_STATES, 0: HREADYOUT low cycles inserted per OKAY data phase. Legal range 0..7.
- CLK_SLAVE  in  1  single clock; all state changes on the rising edge.
- RESET_SLAVE  in  1  synchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; values above 2 are illegal.
- HBURST  in  3  burst type; informational only and not decoded.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready. Tie to HREADYOUT in a single-slave system.
- HREADYOUT  out  1  slave ready; low = wait/error first cycle.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

## Operation
- **Address phase acceptance**
  - A transfer is accepted when HSEL & HTRANS[1] & HREADY are all high at a rising edge.
  - On acceptance the slave latches addr_q = HADDR[ADDR_BITS-1:0], write_q, size_q, and an error flag.
- **Error flag.** Set when any of the following holds:
  - HADDR[31:ADDR_BITS] is non-zero;
  - HSIZE > 2;
  - the halfword is misaligned (HADDR[0] = 1);
  - the word is misaligned (HADDR[1:0] ≠ 0).
- **No-op cycles.** IDLE, BUSY, or HSEL low at an accepting edge start no data phase. The following cycle returns OKAY with zero waits.
- **FSM states:** IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: no data phase pending. HREADYOUT = 1, HRESP = 0.
  - Accepted with error → ERR1.
  - Accepted, no error, WAIT_STATES > 0 → WAIT, with wcnt loaded to WAIT_STATES-1.
  - Accepted, no error, WAIT_STATES = 0 → DATA.
  - WAIT: HREADYOUT = 0, HRESP = 0. wcnt decrements each cycle; at 0 → DATA.
  - DATA: HREADYOUT = 1, HRESP = 0; the transfer completes this cycle.
  - ERR1: HREADYOUT = 0, HRESP = 1 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. No memory access.
  - On leaving DATA or ERR2, a new acceptance on that same edge enters the next state directly (back-to-back pipelining). Otherwise → IDLE.
- **Write**
  - At the rising edge that ends DATA, HWDATA is written to mem[addr_q[ADDR_BITS-1:2]] with byte enables. Byte lanes are little-endian.
  - Byte: lane addr_q[1:0].
  - Halfword: lanes {addr_q[1],0} and {addr_q[1],1}.
  - Word: all four lanes.
  - Unselected lanes are unchanged.
- **Read**
  - In DATA with write_q = 0, HRDATA = mem[addr_q[ADDR_BITS-1:2]] (full word; the master selects lanes).
  - In all other states HRDATA = 0.
- **Read-after-write.** A read whose data phase immediately follows a write data phase to the same word returns the newly written bytes, because the write commits at the edge that starts the read's data phase.
- **Bursts.** Each beat is handled as an independent pipelined transfer. HBURST is ignored, and wrap/increment arithmetic is the master's responsibility.
- **Reset values** (RESET_SLAVE low at an edge): state IDLE, HREADYOUT = 1, HRESP = 0, HRDATA = 0, wcnt = 0.
  - RAM contents are not cleared.
  - Reset mid-transfer aborts it; a pending write is discarded.

## Timing
- Address phase is the cycle of acceptance; the data phase starts on the next cycle.
- OKAY latency:
  - data phase length = WAIT_STATES + 1 cycles;
  - HREADYOUT is low for exactly WAIT_STATES cycles, then high for 1.
- ERROR is always 2 cycles: (HREADYOUT 0, HRESP 1) then (HREADYOUT 1, HRESP 1), independent of WAIT_STATES.
- While HREADYOUT = 0, address-phase inputs are not sampled. The master holds them stable.
- Sustained throughput with WAIT_STATES = 0 is one beat per cycle. INCR4 = 4 NONSEQ/SEQ address cycles plus 1 trailing data cycle.
- HRDATA comes from the registered addr_q and the RAM array. There is no combinational path from HADDR to HRDATA.

## Test plan
- **Reset.** Hold RESET_SLAVE = 0 for 3 cycles → HREADYOUT = 1, HRESP = 0, HRDATA = 0 every cycle.
- **Single word, WAIT_STATES = 0.** Write 0xDEADBEEF to 0x10, then read 0x10 → write data phase 1 cycle OKAY; read data phase HRDATA = 0xDEADBEEF.
- **Byte and halfword lanes.**
  - Word 0x11223344 to 0x20.
  - Byte 0xAA at 0x21 (HWDATA = 0x0000AA00).
  - Halfword 0x5566 at 0x22 (HWDATA = 0x55660000).
  - Read 0x20 → 0x5566AA44.
- **INCR4 back-to-back, WAIT_STATES = 0.** NONSEQ 0x40 then SEQ 0x44/0x48/0x4C with data 1,2,3,4, then INCR4 read → HREADYOUT never low; reads return 1,2,3,4 on consecutive cycles.
- **Wait states, WAIT_STATES = 3.** Single read → HREADYOUT low exactly 3 cycles, then high with valid data.
- **Errors.**
  - Write to 0x0000_0400 (out of range) → HRESP 1 for 2 cycles, HREADYOUT 0 then 1, RAM unchanged.
  - Repeat with a word access at 0x02 (misaligned) → same response.
  - HTRANS = BUSY mid-burst → OKAY, no memory change.
